rgmii_rx_gmii_conv: RTL and testbench



---
 rtl/rgmii_pkg.sv | 35 +++
 rtl/rgmii_inband_status.sv | 54 +++++
 rtl/rgmii_rx_gmii_conv.sv | 141 ++++++++++++++
 tb/tb_rgmii_rx_gmii_conv.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rgmii_pkg
// Description : Shared types and constants for the RGMII receive-side
//               RGMII-to-GMII conversion block.
// Revision    : 1.0 - initial release
// ============================================================================
package rgmii_pkg;

    // Link/latched speed encoding; 2'b11 is handled as 1000M by the converter
    typedef enum logic [1:0] {
        SPD_10   = 2'b00,
        SPD_100  = 2'b01,
        SPD_1000 = 2'b10
    } speed_e;

    // Bit position of the control line inside a 5-bit DDR sample word
    localparam int CTL_BIT = 4;

    // Nibble-assembly state machine (10/100M only)
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HIGH = 2'b01,
        LOW  = 2'b10
    } state_e;

    // In-band status word as carried on rxd[3:0] between frames
    typedef struct packed {
        logic       duplex;
        logic [1:0] speed;
        logic       link;
    } inband_status_t;

endpackage
`default_nettype wire

// File: rtl/rgmii_inband_status.sv
`default_nettype none
// ============================================================================
// Module      : rgmii_inband_status
// Description : Debounces the RGMII in-band status word seen between frames
//               and registers link_up / link_speed / full_duplex once the
//               word has been stable for STATUS_STABLE_CNT samples.
// Revision    : 1.0 - initial release
// ============================================================================
module rgmii_inband_status
    import rgmii_pkg::*;
#(
    parameter int STATUS_STABLE_CNT = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           dv_raw,
    input  logic           er_raw,
    input  logic [3:0]     word,
    output inband_status_t status
);

    localparam logic [3:0] c_stable = 4'(STATUS_STABLE_CNT);

    logic [3:0] r_prev;
    logic [3:0] r_cnt;
    logic [3:0] w_next_cnt;

    // Length of the current run of identical words including this sample
    always_comb begin
        w_next_cnt = 4'd1;
        if ((r_cnt != 4'd0) && (word == r_prev)) begin
            w_next_cnt = (r_cnt == 4'hF) ? 4'hF : r_cnt + 4'd1;
        end
    end

    // Run counter and status registers; frame or error cycles break the run
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 4'd0;
            r_cnt  <= 4'd0;
            status <= '0;
        end else if (dv_raw || er_raw) begin
            r_cnt <= 4'd0;
        end else begin
            r_prev <= word;
            r_cnt  <= w_next_cnt;
            if (w_next_cnt >= c_stable) begin
                status <= inband_status_t'(word);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rgmii_rx_gmii_conv.sv
`default_nettype none
// ============================================================================
// Module      : rgmii_rx_gmii_conv
// Description : Converts rising/falling-edge RGMII samples into a GMII byte
//               stream with a per-byte valid strobe. 1000M uses both edges
//               per cycle; 10/100M assembles bytes from q1 nibbles.
//               Optional in-band status decode: define RGMII_INBAND_STATUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rgmii_rx_gmii_conv
    import rgmii_pkg::*;
#(
    parameter int         STATUS_STABLE_CNT = 4,
    parameter logic [1:0] SPEED_RESET       = 2'b10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic [4:0] rx_q1,
    input  logic [4:0] rx_q2,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    output logic       gmii_rx_valid,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       full_duplex
);

    logic       w_dv_raw;
    logic       w_er_raw;
    logic       w_nibble_mode;
    logic [1:0] r_speed;
    state_e     r_state;
    logic [3:0] r_low;
    logic       r_er_low;
    logic       r_toggle;

    assign w_dv_raw      = rx_q1[CTL_BIT];
    assign w_er_raw      = rx_q1[CTL_BIT] ^ rx_q2[CTL_BIT];
    assign w_nibble_mode = (r_speed == SPD_10) || (r_speed == SPD_100);

    // Speed latch, byte/nibble datapath and nibble-assembly FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            gmii_rxd      <= 8'h00;
            gmii_rx_dv    <= 1'b0;
            gmii_rx_er    <= 1'b0;
            gmii_rx_valid <= 1'b0;
            r_speed       <= SPEED_RESET;
            r_state       <= IDLE;
            r_low         <= 4'h0;
            r_er_low      <= 1'b0;
            r_toggle      <= 1'b0;
        end else begin
            // Speed only changes between frames so a frame never splits modes
            if ((r_state == IDLE) && !w_dv_raw) begin
                r_speed <= speed;
            end

            if (!w_nibble_mode) begin
                gmii_rxd      <= {rx_q2[3:0], rx_q1[3:0]};
                gmii_rx_dv    <= w_dv_raw;
                gmii_rx_er    <= w_er_raw;
                gmii_rx_valid <= 1'b1;
                r_state       <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_dv_raw) begin
                            r_low         <= rx_q1[3:0];
                            r_er_low      <= w_er_raw;
                            gmii_rx_valid <= 1'b0;
                            r_state       <= HIGH;
                        end else begin
                            // Idle bytes at the nibble-rate byte cadence
                            gmii_rxd      <= 8'h00;
                            gmii_rx_dv    <= 1'b0;
                            gmii_rx_er    <= 1'b0;
                            gmii_rx_valid <= r_toggle;
                            r_toggle      <= ~r_toggle;
                        end
                    end
                    HIGH: begin
                        gmii_rx_valid <= 1'b1;
                        gmii_rx_dv    <= 1'b1;
                        if (w_dv_raw) begin
                            gmii_rxd   <= {rx_q1[3:0], r_low};
                            gmii_rx_er <= r_er_low | w_er_raw;
                            r_state    <= LOW;
                        end else begin
                            // Odd nibble count: flush the half byte as errored
                            gmii_rxd   <= {4'h0, r_low};
                            gmii_rx_er <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                    LOW: begin
                        gmii_rx_valid <= 1'b0;
                        if (w_dv_raw) begin
                            r_low    <= rx_q1[3:0];
                            r_er_low <= w_er_raw;
                            r_state  <= HIGH;
                        end else begin
                            r_state  <= IDLE;
                        end
                    end
                    default: begin
                        gmii_rx_valid <= 1'b0;
                        r_state       <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef RGMII_INBAND_STATUS_EN
    inband_status_t w_status;

    rgmii_inband_status #(
        .STATUS_STABLE_CNT (STATUS_STABLE_CNT)
    ) u_inband_status (
        .clk    (clk),
        .rst    (rst),
        .dv_raw (w_dv_raw),
        .er_raw (w_er_raw),
        .word   (rx_q1[3:0]),
        .status (w_status)
    );

    assign link_up     = w_status.link;
    assign link_speed  = w_status.speed;
    assign full_duplex = w_status.duplex;
`else
    assign link_up     = 1'b0;
    assign link_speed  = 2'b00;
    assign full_duplex = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rgmii_rx_gmii_conv.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgmii_rx_gmii_conv
// Description : Self-checking bench for rgmii_rx_gmii_conv: gigabit byte
//               mode, nibble-mode frame assembly, speed latching, reset and
//               (when RGMII_INBAND_STATUS_EN is defined) in-band status.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgmii_rx_gmii_conv;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] speed;
    logic [4:0] rx_q1;
    logic [4:0] rx_q2;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic       gmii_rx_valid;
    logic       link_up;
    logic [1:0] link_speed;
    logic       full_duplex;

    int checks   = 0;
    int failures = 0;

    rgmii_rx_gmii_conv #(
        .STATUS_STABLE_CNT (4),
        .SPEED_RESET       (2'b10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .speed         (speed),
        .rx_q1         (rx_q1),
        .rx_q2         (rx_q2),
        .gmii_rxd      (gmii_rxd),
        .gmii_rx_dv    (gmii_rx_dv),
        .gmii_rx_er    (gmii_rx_er),
        .gmii_rx_valid (gmii_rx_valid),
        .link_up       (link_up),
        .link_speed    (link_speed),
        .full_duplex   (full_duplex)
    );

    always #5 clk = ~clk;

    // Apply one cycle of samples, then look at outputs 1 time unit past the edge
    task automatic step(input logic [4:0] q1, input logic [4:0] q2);
        rx_q1 = q1;
        rx_q2 = q2;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        step({1'b0, 4'($urandom)}, {1'b0, 4'($urandom)});
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        speed = 2'b10;
        step(5'h00, 5'h00);
        step(5'h1F, 5'h1F);
        checks++;
        if ({gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd} !== 11'h0) begin
            failures++;
            $display("FAIL reset_gmii got %h expected %h",
                     {gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd}, 11'h0);
        end
        checks++;
        if ({link_up, link_speed, full_duplex} !== 4'h0) begin
            failures++;
            $display("FAIL reset_status got %h expected %h",
                     {link_up, link_speed, full_duplex}, 4'h0);
        end
        rst = 1'b0;
    endtask

    // Fixed 1000M cases: plain byte, error during frame, carrier extension
    task automatic test_gig_directed();
        logic [4:0]  q1s [3] = '{5'h15, 5'h13, 5'h0F};
        logic [4:0]  q2s [3] = '{5'h1A, 5'h07, 5'h1F};
        logic [10:0] exps[3] = '{{3'b110, 8'hA5}, {3'b111, 8'h73}, {3'b101, 8'hFF}};
        speed = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step(q1s[i], q2s[i]);
            checks++;
            if ({gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd} !== exps[i]) begin
                failures++;
                $display("FAIL gig_directed[%0d] got %h expected %h", i,
                         {gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd}, exps[i]);
            end
        end
    endtask

    // Random 1000M traffic: every cycle is a byte built from both edges
    task automatic test_gig_random();
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic [10:0] exp_w;
        speed = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
        for (int i = 0; i < 24; i++) begin
            q1    = 5'($urandom);
            q2    = 5'($urandom);
            exp_w = {1'b1, q1[4], q1[4] ^ q2[4], q2[3:0], q1[3:0]};
            step(q1, q2);
            checks++;
            if ({gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd} !== exp_w) begin
                failures++;
                $display("FAIL gig_random[%0d] got %h expected %h", i,
                         {gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd}, exp_w);
            end
        end
    endtask

    // Idle in nibble mode: idle bytes strobed on every second cycle
    task automatic test_nibble_idle();
        logic prev_v;
        speed = 2'b01;
        idle_step();
        idle_step();
        for (int i = 0; i < 8; i++) begin
            idle_step();
            checks++;
            if ({gmii_rx_dv, gmii_rx_er, gmii_rxd} !== 10'h0 ||
                (i > 0 && gmii_rx_valid === prev_v)) begin
                failures++;
                $display("FAIL nibble_idle[%0d] got v=%b dv=%b er=%b rxd=%h expected v=%b dv=0 er=0 rxd=00",
                         i, gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd, ~prev_v);
            end
            prev_v = gmii_rx_valid;
        end
    endtask

    // Drive one nibble-mode frame; expected bytes come from pairing nibbles
    task automatic run_frame(input int n, input logic [3:0] d[16], input logic e[16],
                             input int tag);
        logic [9:0] exp_q[$];
        logic [9:0] exp_b;
        int         bi;
        for (int k = 0; k + 1 < n; k += 2) begin
            exp_q.push_back({1'b1, e[k] | e[k+1], d[k+1], d[k]});
        end
        if (n % 2 == 1) exp_q.push_back({1'b1, 1'b1, 4'h0, d[n-1]});
        bi = 0;
        for (int i = 0; i < n; i++) begin
            step({1'b1, d[i]}, {1'b1 ^ e[i], 4'($urandom)});
            checks++;
            if (i % 2 == 1) begin
                exp_b = exp_q[bi];
                bi++;
                if (gmii_rx_valid !== 1'b1 || {gmii_rx_dv, gmii_rx_er, gmii_rxd} !== exp_b) begin
                    failures++;
                    $display("FAIL frame%0d_byte nib %0d got v=%b %h expected v=1 %h",
                             tag, i, gmii_rx_valid, {gmii_rx_dv, gmii_rx_er, gmii_rxd}, exp_b);
                end
            end else if (gmii_rx_valid !== 1'b0) begin
                failures++;
                $display("FAIL frame%0d_gap nib %0d got v=%b expected v=0", tag, i, gmii_rx_valid);
            end
        end
        step({1'b0, 4'($urandom)}, {1'b0, 4'($urandom)});
        checks++;
        if (n % 2 == 1) begin
            exp_b = exp_q[bi];
            if (gmii_rx_valid !== 1'b1 || {gmii_rx_dv, gmii_rx_er, gmii_rxd} !== exp_b) begin
                failures++;
                $display("FAIL frame%0d_odd_tail got v=%b %h expected v=1 %h",
                         tag, gmii_rx_valid, {gmii_rx_dv, gmii_rx_er, gmii_rxd}, exp_b);
            end
        end else if (gmii_rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL frame%0d_end got v=%b expected v=0", tag, gmii_rx_valid);
        end
    endtask

    task automatic test_nibble_directed();
        logic [3:0] d[16];
        logic       e[16];
        for (int i = 0; i < 16; i++) begin
            d[i] = 4'h0;
            e[i] = 1'b0;
        end
        speed = 2'b01;
        idle_step();
        idle_step();
        d[0] = 4'h5; d[1] = 4'h5; d[2] = 4'h5; d[3] = 4'hD;
        run_frame(4, d, e, 100);
        idle_step();
        idle_step();
        d[0] = 4'h7; d[1] = 4'h3; d[2] = 4'h9;
        run_frame(3, d, e, 101);
    endtask

    task automatic test_nibble_random();
        logic [3:0] d[16];
        logic       e[16];
        for (int f = 0; f < 12; f++) begin
            speed = 2'($urandom_range(0, 1));
            idle_step();
            idle_step();
            for (int i = 0; i < 16; i++) begin
                d[i] = 4'($urandom);
                e[i] = ($urandom_range(0, 5) == 0);
            end
            run_frame(int'($urandom_range(1, 9)), d, e, f);
        end
    endtask

    // Speed change mid-frame waits for the next idle before taking effect
    task automatic test_speed_switch();
        speed = 2'b00;
        idle_step();
        idle_step();
        step(5'h11, 5'h10);
        step(5'h12, 5'h1F);
        checks++;
        if ({gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd} !== {3'b110, 8'h21}) begin
            failures++;
            $display("FAIL switch_byte0 got %h expected %h",
                     {gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd}, {3'b110, 8'h21});
        end
        speed = 2'b10;
        step(5'h13, 5'h1E);
        checks++;
        if (gmii_rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL switch_midframe_valid got %b expected 0", gmii_rx_valid);
        end
        step(5'h14, 5'h1D);
        checks++;
        if ({gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd} !== {3'b110, 8'h43}) begin
            failures++;
            $display("FAIL switch_byte1 got %h expected %h",
                     {gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd}, {3'b110, 8'h43});
        end
        step(5'h00, 5'h00);
        idle_step();
        step(5'h15, 5'h1A);
        checks++;
        if ({gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd} !== {3'b110, 8'hA5}) begin
            failures++;
            $display("FAIL switch_gig_after got %h expected %h",
                     {gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd}, {3'b110, 8'hA5});
        end
    endtask

    // Reset in the middle of a nibble frame drops the half byte
    task automatic test_reset_mid_frame();
        speed = 2'b01;
        idle_step();
        idle_step();
        step(5'h1A, 5'h10);
        rst = 1'b1;
        step(5'h1B, 5'h10);
        checks++;
        if ({gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd, link_up, link_speed, full_duplex} !== 15'h0) begin
            failures++;
            $display("FAIL rst_midframe got %h expected 0",
                     {gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd, link_up, link_speed, full_duplex});
        end
        rst = 1'b0;
        step(5'h13, 5'h16);
        checks++;
        if ({gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd} !== {3'b110, 8'h63}) begin
            failures++;
            $display("FAIL rst_speed_default got %h expected %h",
                     {gmii_rx_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd}, {3'b110, 8'h63});
        end
    endtask

`ifdef RGMII_INBAND_STATUS_EN
    // Status words: {duplex, speed[1:0], link}; update on 4th identical sample
    task automatic test_inband();
        logic [4:0] words[$];
        logic [3:0] exps[$];
        rst = 1'b1;
        step(5'h00, 5'h00);
        rst = 1'b0;
        speed = 2'b10;
        words = '{5'h0D, 5'h0D, 5'h0D, 5'h0D,
                  5'h02, 5'h02, 5'h02, 5'h05, 5'h02, 5'h02, 5'h02,
                  5'h02,
                  5'h0D, 5'h0D, 5'h1D, 5'h0D, 5'h0D, 5'h0D};
        exps  = '{4'h0, 4'h0, 4'h0, 4'hD,
                  4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD,
                  4'h2,
                  4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2};
        for (int i = 0; i < words.size(); i++) begin
            step(words[i], {words[i][4], 4'($urandom)});
            checks++;
            if ({full_duplex, link_speed, link_up} !== exps[i]) begin
                failures++;
                $display("FAIL inband[%0d] got %h expected %h", i,
                         {full_duplex, link_speed, link_up}, exps[i]);
            end
        end
        step(5'h0D, 5'h00);
        rst = 1'b1;
        step(5'h0D, 5'h00);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(5'h0D, 5'h00);
            checks++;
            if ({full_duplex, link_speed, link_up} !== ((i == 3) ? 4'hD : 4'h0)) begin
                failures++;
                $display("FAIL inband_rst[%0d] got %h expected %h", i,
                         {full_duplex, link_speed, link_up}, (i == 3) ? 4'hD : 4'h0);
            end
        end
    endtask
`else
    task automatic test_inband();
        speed = 2'b10;
        for (int i = 0; i < 6; i++) begin
            step(5'h0D, 5'h00);
            checks++;
            if ({full_duplex, link_speed, link_up} !== 4'h0) begin
                failures++;
                $display("FAIL inband_disabled[%0d] got %h expected 0", i,
                         {full_duplex, link_speed, link_up});
            end
        end
    endtask
`endif

    initial begin
        rst   = 1'b1;
        speed = 2'b10;
        rx_q1 = 5'h00;
        rx_q2 = 5'h00;
        test_reset();
        test_gig_directed();
        test_gig_random();
        test_nibble_idle();
        test_nibble_directed();
        test_nibble_random();
        test_speed_switch();
        test_reset_mid_frame();
        test_inband();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
